input_debounce: RTL and testbench

//   Debounces and synchronises the raw board switches and push-buttons before they

---
 rtl/input_debounce.sv | 87 ++++++++
 tb/tb_input_debounce.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/input_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for raw switches and keys.
// Outputs clean levels and registered one-cycle rise/fall pulses.
module input_debounce #(
    parameter int             N        = 8,
    parameter int             CNT_W    = 16,
    parameter int             DEBOUNCE = 50000,
    parameter logic [N-1:0]   RST_VAL  = 8'h0F
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] raw_in,
    output logic [N-1:0] db_out,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         changed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [N-1:0]     s1_r;
    logic [N-1:0]     s2_r;
    logic [CNT_W-1:0] cnt_r [N];
    logic [N-1:0]     diff_s;
    logic [N-1:0]     accept_s;

    // Accept decision: bit differs from db_out and has been stable long enough.
    always_comb begin
        diff_s   = s2_r ^ db_out;
        accept_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (en && diff_s[i] && (cnt_r[i] == CNT_MAX)) begin
                accept_s[i] = 1'b1;
            end else begin
                accept_s[i] = 1'b0;
            end
        end
    end

    // Two-flop synchroniser; keeps sampling even while en is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_r <= RST_VAL;
            s2_r <= RST_VAL;
        end else begin
            s1_r <= raw_in;
            s2_r <= s1_r;
        end
    end

    // Per-bit stability counters; any agreement with db_out restarts the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else if (en) begin
            for (int i = 0; i < N; i++) begin
                if (!diff_s[i] || accept_s[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= cnt_r[i];
            end
        end
    end

    // Debounced level and registered edge pulses; accept_s is already gated by en.
    always_ff @(posedge clk) begin
        if (!rst) begin
            db_out  <= RST_VAL;
            rise    <= {N{1'b0}};
            fall    <= {N{1'b0}};
            changed <= 1'b0;
        end else begin
            db_out  <= (db_out & ~accept_s) | (s2_r & accept_s);
            rise    <= accept_s & s2_r;
            fall    <= accept_s & ~s2_r;
            changed <= |accept_s;
        end
    end

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with DEBOUNCE=4, N=8, RST_VAL=8'h0F.
module tb_input_debounce;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] raw_in;
    logic [7:0] db_out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       changed;

    int checks_cnt = 0;
    int errors_cnt = 0;

    input_debounce #(
        .N        (8),
        .CNT_W    (16),
        .DEBOUNCE (4),
        .RST_VAL  (8'h0F)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .raw_in  (raw_in),
        .db_out  (db_out),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_db, input logic [7:0] e_rise,
                              input logic [7:0] e_fall, input logic e_chg);
        check_value({tag, "_db"},   {24'h0, db_out}, {24'h0, e_db});
        check_value({tag, "_rise"}, {24'h0, rise},   {24'h0, e_rise});
        check_value({tag, "_fall"}, {24'h0, fall},   {24'h0, e_fall});
        check_value({tag, "_chg"},  {31'h0, changed}, {31'h0, e_chg});
    endtask

    initial begin
        rst    = 1'b0;
        en     = 1'b1;
        raw_in = 8'hA5;

        // 1. reset state
        repeat (3) step();
        check_outs("reset", 8'h0F, 8'h00, 8'h00, 1'b0);

        // 2. bit 7 rises, accepted after edge k+5
        rst    = 1'b1;
        raw_in = 8'h0F;
        repeat (3) step();
        check_outs("idle", 8'h0F, 8'h00, 8'h00, 1'b0);
        raw_in = 8'h8F;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c < 6)       check_outs("rise_wait", 8'h0F, 8'h00, 8'h00, 1'b0);
            else if (c == 6) check_outs("rise_acc",  8'h8F, 8'h80, 8'h00, 1'b1);
            else             check_outs("rise_after", 8'h8F, 8'h00, 8'h00, 1'b0);
        end

        // 3. bounce on bit 0 shorter than DEBOUNCE never propagates
        for (int rep = 0; rep < 5; rep++) begin
            for (int j = 0; j < 4; j++) begin
                raw_in = (j < 3) ? 8'h8E : 8'h8F;
                step();
                check_value("glitch_db0",   {31'h0, db_out[0]}, 32'h1);
                check_value("glitch_fall0", {31'h0, fall[0]},   32'h0);
            end
        end
        repeat (4) begin
            step();
            check_value("glitch_settle_db", {24'h0, db_out}, 32'h8F);
            check_value("glitch_settle_fall", {24'h0, fall}, 32'h00);
        end

        // 4. four keys drop together
        raw_in = 8'h80;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c < 6)       check_outs("fall_wait", 8'h8F, 8'h00, 8'h00, 1'b0);
            else if (c == 6) check_outs("fall_acc",  8'h80, 8'h00, 8'h0F, 1'b1);
            else             check_outs("fall_after", 8'h80, 8'h00, 8'h00, 1'b0);
        end

        // 5. freeze mid-count on bit 5 (count reaches 2, holds, resumes)
        raw_in = 8'hA0;
        for (int c = 1; c <= 4; c++) begin
            step();
            check_outs("frz_pre", 8'h80, 8'h00, 8'h00, 1'b0);
        end
        en = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            check_outs("frz_hold", 8'h80, 8'h00, 8'h00, 1'b0);
        end
        en = 1'b1;
        step();
        check_outs("frz_res1", 8'h80, 8'h00, 8'h00, 1'b0);
        step();
        check_outs("frz_res2", 8'hA0, 8'h20, 8'h00, 1'b1);
        step();
        check_outs("frz_after", 8'hA0, 8'h00, 8'h00, 1'b0);

        // 6. reset one cycle before bit 6 would be accepted
        raw_in = 8'hE0;
        for (int c = 1; c <= 4; c++) begin
            step();
            check_outs("rstmid_pre", 8'hA0, 8'h00, 8'h00, 1'b0);
        end
        rst = 1'b0;
        step();
        check_outs("rstmid_rst", 8'h0F, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c < 6)       check_outs("rstmid_wait", 8'h0F, 8'h00, 8'h00, 1'b0);
            else if (c == 6) check_outs("rstmid_acc",  8'hE0, 8'hE0, 8'h0F, 1'b1);
            else             check_outs("rstmid_after", 8'hE0, 8'h00, 8'h00, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
